// File: rtl/mi_rd_stream.sv
// Read-stream front-end: splits a {address, length} request into bounded mi_* read bursts
// and returns the data as a valid/ready stream through a credit-checked show-ahead FIFO.
module mi_rd_stream #(
    parameter int AW         = 20,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_len,
    input  logic          req_valid,
    output logic          req_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mi_addr,
    output logic [6:0]    mi_len,
    output logic          mi_rw,
    output logic          mi_valid,
    input  logic          mi_ready,
    input  logic [31:0]   mi_rdata,
    input  logic          mi_rstb,
    input  logic          mi_rlast
);

    localparam int          PW = $clog2(FIFO_DEPTH);
    localparam int          CW = PW + 1;
    localparam logic [15:0] BL = 16'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [15:0]   iss_rem, rx_rem, burst_n;
    logic [CW-1:0] outstanding, fifo_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [32:0]   mem [FIFO_DEPTH];
    logic          req_fire, mi_fire, rx_take, pop, fifo_empty, head_last;
    logic          credit_ok, issue_go, last_pop;
    logic          unused_rlast;

    assign unused_rlast = mi_rlast;

    assign req_ready  = (state == IDLE) && !rst;
    assign req_fire   = req_valid && req_ready;
    assign mi_fire    = mi_valid && mi_ready;
    assign rx_take    = mi_rstb && (rx_rem != 16'd0);
    assign fifo_empty = (fifo_cnt == '0);
    assign out_valid  = !fifo_empty;
    assign head_last  = mem[rd_ptr][32];
    assign out_data   = out_valid ? mem[rd_ptr][31:0] : 32'd0;
    assign out_last   = out_valid && head_last;
    assign pop        = out_valid && out_ready;
    assign last_pop   = pop && head_last;
    assign busy       = (state != IDLE);
    assign mi_rw      = 1'b1;

    // A burst is only issued when every word it can return already has a FIFO slot reserved.
    assign burst_n   = (iss_rem < BL) ? iss_rem : BL;
    assign credit_ok = (32'(fifo_cnt) + 32'(outstanding) + 32'(burst_n)) <= 32'(FIFO_DEPTH);
    assign issue_go  = (state == ISSUE) && !mi_valid && credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire && req_len != 16'd0) state_nxt = ISSUE;
            ISSUE:   if (mi_fire && iss_rem == burst_n) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            iss_rem  <= '0;
            mi_valid <= 1'b0;
            mi_addr  <= '0;
            mi_len   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (req_fire) begin
                addr    <= req_addr;
                iss_rem <= req_len;
                if (req_len == 16'd0) done <= 1'b1;
            end
            if (issue_go) begin
                mi_valid <= 1'b1;
                mi_addr  <= addr;
                mi_len   <= 7'(burst_n - 16'd1);
            end
            if (mi_fire) begin
                mi_valid <= 1'b0;
                addr     <= addr + AW'(burst_n);
                iss_rem  <= iss_rem - burst_n;
            end
            if (state == DRAIN && last_pop) done <= 1'b1;
        end
    end

    // Words arriving with nothing left to receive (e.g. after a reset) are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_rem      <= '0;
            outstanding <= '0;
        end else begin
            if (req_fire)     rx_rem <= req_len;
            else if (rx_take) rx_rem <= rx_rem - 16'd1;
            outstanding <= outstanding + (mi_fire ? CW'(burst_n) : '0) - CW'(rx_take);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_take) mem[wr_ptr] <= {rx_rem == 16'd1, mi_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rx_take) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(rx_take) - CW'(pop);
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rx_take && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mi_rd_stream.sv
// Bench for mi_rd_stream: a memory responder plus a request-level model (expected commands,
// expected words, FIFO credit) checked every cycle, with directed scenarios and literal pins.
module tb_mi_rd_stream;

    localparam int AW    = 20;
    localparam int BL    = 16;
    localparam int DEPTH = 32;

    typedef struct packed { logic [AW-1:0] addr; logic [6:0] len; } cmd_t;
    typedef struct packed { logic [31:0] data; logic last; } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_len;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] mi_addr;
    logic [6:0]    mi_len;
    logic          mi_rw;
    logic          mi_valid;
    logic          mi_ready = 1'b0;
    logic [31:0]   mi_rdata = 32'd0;
    logic          mi_rstb  = 1'b0;
    logic          mi_rlast = 1'b0;

    cmd_t          cmd_q[$];
    cmd_t          cmd_log[$];
    word_t         exp_q[$];
    logic [AW-1:0] rsp_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   fires = 0, pops = 0, dones = 0, stalled = 0;
    int   outstanding_m = 0, fifo_m = 0, stale = 0;
    int   stall = 0, gap = 0;
    logic busy_m = 1'b0, done_due = 1'b0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [6:0]    prev_l = '0;

    mi_rd_stream #(.AW(AW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
        .mi_ready(mi_ready), .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'(a) ^ 32'hA500_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory responder: accepts commands unless stalled, returns one word per cycle with optional gaps.
    initial begin
        int rc;
        logic [AW-1:0] a;
        rc = 0;
        forever begin
            @(posedge clk); #1;
            rc++;
            if (stall > 0) begin
                mi_ready = 1'b0;
                stall--;
            end else begin
                mi_ready = 1'b1;
            end
            if (rsp_q.size() > 0 && !(gap > 0 && rc % gap == 0)) begin
                a        = rsp_q.pop_front();
                mi_rstb  = 1'b1;
                mi_rdata = mem_word(a);
                mi_rlast = (rsp_q.size() == 0);
            end else begin
                mi_rstb  = 1'b0;
                mi_rdata = 32'd0;
                mi_rlast = 1'b0;
            end
        end
    end

    // Request-level model and per-cycle comparison.
    initial begin
        logic done_next, busy_next;
        cmd_t c;
        word_t w;
        logic [AW-1:0] cur;
        int rem, n;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("reset_flags", 64'({mi_valid, out_valid, busy, done, req_ready}), 64'd0);
                checkOutput("reset_out_data", 64'(out_data), 64'd0);
                exp_q.delete();
                cmd_q.delete();
                outstanding_m = 0;
                fifo_m        = 0;
                stale         = rsp_q.size();
                busy_m        = 1'b0;
                done_due      = 1'b0;
                prev_v        = 1'b0;
                prev_r        = 1'b0;
            end else begin
                checkOutput("done", 64'(done), 64'(done_due));
                checkOutput("busy", 64'(busy), 64'(busy_m));
                checkOutput("req_ready", 64'(req_ready), 64'(!busy_m));
                checkOutput("out_valid", 64'(out_valid), 64'(fifo_m > 0));
                if (done) dones++;
                if (prev_v && !prev_r) begin
                    checkOutput("hold_valid", 64'(mi_valid), 64'd1);
                    checkOutput("hold_addr", 64'(mi_addr), 64'(prev_a));
                    checkOutput("hold_len", 64'(mi_len), 64'(prev_l));
                end else if (prev_v && prev_r) begin
                    checkOutput("valid_gap", 64'(mi_valid), 64'd0);
                end
                if (mi_valid && !mi_ready) stalled++;

                done_next = 1'b0;
                busy_next = busy_m;
                if (req_valid && req_ready) begin
                    if (req_len == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next = 1'b1;
                        rem = int'(req_len);
                        for (int i = 0; i < rem; i++)
                            exp_q.push_back('{data: mem_word(req_addr + AW'(i)), last: (i == rem - 1)});
                        cur = req_addr;
                        while (rem > 0) begin
                            n = (rem < BL) ? rem : BL;
                            cmd_q.push_back('{addr: cur, len: 7'(n - 1)});
                            cur = cur + AW'(n);
                            rem -= n;
                        end
                    end
                end
                if (mi_valid && mi_ready) begin
                    fires++;
                    cmd_log.push_back('{addr: mi_addr, len: mi_len});
                    checkOutput("mi_rw", 64'(mi_rw), 64'd1);
                    if (cmd_q.size() == 0) begin
                        checkOutput("unexpected_cmd", 64'd1, 64'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        checkOutput("cmd_addr", 64'(mi_addr), 64'(c.addr));
                        checkOutput("cmd_len", 64'(mi_len), 64'(c.len));
                    end
                    for (int i = 0; i <= int'(mi_len); i++) rsp_q.push_back(mi_addr + AW'(i));
                    outstanding_m += int'(mi_len) + 1;
                end
                if (mi_rstb) begin
                    if (stale > 0) begin
                        stale--;
                    end else begin
                        outstanding_m--;
                        fifo_m++;
                    end
                end
                if (out_valid && out_ready) begin
                    pops++;
                    fifo_m--;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_word", 64'd1, 64'd0);
                    end else begin
                        w = exp_q.pop_front();
                        checkOutput("out_data", 64'(out_data), 64'(w.data));
                        checkOutput("out_last", 64'(out_last), 64'(w.last));
                        if (w.last) begin
                            done_next = 1'b1;
                            busy_next = 1'b0;
                        end
                    end
                end
                checkOutput("credit", 64'(fifo_m + outstanding_m <= DEPTH), 64'd1);
                prev_v   = mi_valid;
                prev_r   = mi_ready;
                prev_a   = mi_addr;
                prev_l   = mi_len;
                done_due = done_next;
                busy_m   = busy_next;
            end
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [15:0] len);
        logic taken;
        taken = 1'b0;
        @(posedge clk); #1;
        req_addr  = a;
        req_len   = len;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !taken; i++) begin
            @(negedge clk);
            if (req_ready) taken = 1'b1;
        end
        checkOutput("req_accepted", 64'(taken), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int base, input int budget);
        for (int i = 0; i < budget && dones <= base; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("done_seen", 64'(dones > base), 64'd1);
    endtask

    initial begin
        int f0, p0, d0, l0, s0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Three bursts, the last one partial, with gaps in the returned data.
        gap = 3;
        f0 = fires; p0 = pops; d0 = dones; l0 = cmd_log.size();
        applyStimulus(20'h00100, 16'd40);
        waitDone(d0, 500);
        repeat (5) @(posedge clk);
        checkOutput("t1_fires", 64'(fires - f0), 64'd3);
        checkOutput("t1_cmd0", 64'(cmd_log[l0]), 64'({20'h00100, 7'd15}));
        checkOutput("t1_cmd1", 64'(cmd_log[l0 + 1]), 64'({20'h00110, 7'd15}));
        checkOutput("t1_cmd2", 64'(cmd_log[l0 + 2]), 64'({20'h00120, 7'd7}));
        checkOutput("t1_words", 64'(pops - p0), 64'd40);
        checkOutput("t1_done_once", 64'(dones - d0), 64'd1);

        // Stalled consumer: credit holds the third burst until 16 words are popped.
        gap = 0;
        out_ready = 1'b0;
        f0 = fires; p0 = pops; d0 = dones;
        applyStimulus(20'h02000, 16'd64);
        repeat (80) @(posedge clk);
        #1;
        checkOutput("t2_fires_held", 64'(fires - f0), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && pops - p0 < 16; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checkOutput("t2_pops16", 64'(pops - p0), 64'd16);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t2_fires_third", 64'(fires - f0), 64'd3);
        out_ready = 1'b1;
        waitDone(d0, 500);
        checkOutput("t2_fires_all", 64'(fires - f0), 64'd4);
        checkOutput("t2_words", 64'(pops - p0), 64'd64);

        // Empty request: done only, no bus traffic.
        f0 = fires; p0 = pops; d0 = dones;
        applyStimulus(20'h00555, 16'd0);
        waitDone(d0, 20);
        repeat (5) @(posedge clk);
        checkOutput("t3_fires", 64'(fires - f0), 64'd0);
        checkOutput("t3_words", 64'(pops - p0), 64'd0);
        checkOutput("t3_done_once", 64'(dones - d0), 64'd1);

        // Address wrap at the top of the address space.
        f0 = fires; p0 = pops; d0 = dones; l0 = cmd_log.size();
        applyStimulus(20'hFFFF0, 16'd24);
        waitDone(d0, 300);
        checkOutput("t4_cmd0", 64'(cmd_log[l0]), 64'({20'hFFFF0, 7'd15}));
        checkOutput("t4_cmd1_wrap", 64'(cmd_log[l0 + 1]), 64'({20'h00000, 7'd7}));
        checkOutput("t4_words", 64'(pops - p0), 64'd24);

        // Command back-pressure for ~10 cycles.
        f0 = fires; p0 = pops; d0 = dones; s0 = stalled;
        @(posedge clk); #1;
        stall = 14;
        applyStimulus(20'h00800, 16'd16);
        waitDone(d0, 300);
        checkOutput("t5_fires_once", 64'(fires - f0), 64'd1);
        checkOutput("t5_stalled", 64'(stalled - s0 >= 8), 64'd1);
        checkOutput("t5_words", 64'(pops - p0), 64'd16);

        // Reset mid-burst; late words must be dropped, then a normal request.
        gap = 2;
        p0 = pops;
        applyStimulus(20'h00300, 16'd48);
        for (int i = 0; i < 300 && pops - p0 < 5; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        checkOutput("t6_words_pending", 64'(rsp_q.size() > 0), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        p0 = pops;
        for (int i = 0; i < 300 && rsp_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("t6_drained", 64'(rsp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_dropped", 64'(out_valid), 64'd0);
        checkOutput("t6_no_pops", 64'(pops - p0), 64'd0);
        gap = 0;
        d0 = dones;
        applyStimulus(20'h00400, 16'd20);
        waitDone(d0, 300);
        checkOutput("t6_words_after", 64'(pops - p0), 64'd20);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
